// File: rtl/bcx_partitioned_nonce_processor.sv
// Partitioned nonce sweeper: issues one candidate per cycle, tracks tags through the hash pipe, captures the winner.
// Optional macro BCX_SWEEP_RESUME_EN keeps sweeping after wins and adds a saturating win_count output.
module bcx_partitioned_nonce_processor #(
  parameter int PARTITIONBITS   = 1,
  parameter int PROCESSORNUMBER = 0,
  parameter int NONCE_BITS      = 32,
  parameter int PIPE_DEPTH      = 4,
  parameter int PAYLOAD_W       = 352,
  parameter int PASS_STAGES     = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_newblock,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  output logic                 out_newblock,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [31:0]          nonce_o,
  output logic                 nonce_valid_o,
  input  logic                 hash_success_i,
  output logic                 victory,
  output logic [31:0]          victory_nonce,
  output logic                 exhausted,
  output logic                 sweeping
`ifdef BCX_SWEEP_RESUME_EN
  ,
  output logic [7:0]           win_count
`endif
);

  localparam int CNT_W = NONCE_BITS - PARTITIONBITS;
  localparam logic [PARTITIONBITS-1:0] PART_ID = PARTITIONBITS'(PROCESSORNUMBER);

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   counter_reg, counter_next;
  logic               victory_reg, victory_next;
  logic [31:0]        victory_nonce_reg, victory_nonce_next;
  logic               exhausted_reg, exhausted_next;
  logic               tag_valid_reg [PIPE_DEPTH];
  logic [31:0]        tag_nonce_reg [PIPE_DEPTH];
  logic               tag_flush;
  logic               pipe_busy;
  logic               start_req;
  logic               hit;
  logic               last_issue;
  logic [NONCE_BITS-1:0] cand_nonce;
`ifdef BCX_SWEEP_RESUME_EN
  logic [7:0]         win_count_reg, win_count_next;
`endif

  assign start_req     = in_valid & in_newblock;
  assign last_issue    = &counter_reg;
  assign cand_nonce    = {counter_reg, PART_ID};
  assign nonce_valid_o = (state_reg == SWEEP);
  assign nonce_o       = nonce_valid_o ? 32'(cand_nonce) : 32'd0;
  assign hit           = tag_valid_reg[PIPE_DEPTH-1] & hash_success_i;
  assign sweeping      = (state_reg == SWEEP) || (state_reg == DRAIN);
  assign victory       = victory_reg;
  assign victory_nonce = victory_nonce_reg;
  assign exhausted     = exhausted_reg;
`ifdef BCX_SWEEP_RESUME_EN
  assign win_count     = win_count_reg;
`endif

  // The tag at the output stage is being retired this cycle, so only younger stages keep the pipe busy.
  always_comb begin
    pipe_busy = 1'b0;
    for (int i = 0; i < PIPE_DEPTH - 1; i++) begin
      pipe_busy = pipe_busy | tag_valid_reg[i];
    end
  end

  always_comb begin
    state_next         = state_reg;
    counter_next       = counter_reg;
`ifdef BCX_SWEEP_RESUME_EN
    victory_next       = 1'b0;
    win_count_next     = win_count_reg;
`else
    victory_next       = victory_reg;
`endif
    victory_nonce_next = victory_nonce_reg;
    exhausted_next     = exhausted_reg;
    tag_flush          = 1'b0;

    if (start_req) begin
      state_next     = SWEEP;
      counter_next   = '0;
      victory_next   = 1'b0;
      exhausted_next = 1'b0;
      tag_flush      = 1'b1;
`ifdef BCX_SWEEP_RESUME_EN
      win_count_next = 8'd0;
`endif
    end else begin
      if (state_reg == SWEEP) begin
        if (last_issue) begin
          state_next = DRAIN;
        end else begin
          counter_next = counter_reg + CNT_W'(1);
        end
      end

      if (hit && sweeping) begin
        victory_next       = 1'b1;
        victory_nonce_next = tag_nonce_reg[PIPE_DEPTH-1];
`ifdef BCX_SWEEP_RESUME_EN
        if (win_count_reg != 8'hFF) begin
          win_count_next = win_count_reg + 8'd1;
        end
`else
        state_next = DONE;
        tag_flush  = 1'b1;
`endif
      end

`ifdef BCX_SWEEP_RESUME_EN
      if (state_reg == DRAIN && !pipe_busy) begin
        state_next     = DONE;
        exhausted_next = (win_count_reg == 8'd0) && !hit;
      end
`else
      if (state_reg == DRAIN && !pipe_busy && !hit) begin
        state_next     = DONE;
        exhausted_next = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg         <= IDLE;
      counter_reg       <= '0;
      victory_reg       <= 1'b0;
      victory_nonce_reg <= 32'd0;
      exhausted_reg     <= 1'b0;
`ifdef BCX_SWEEP_RESUME_EN
      win_count_reg     <= 8'd0;
`endif
    end else begin
      state_reg         <= state_next;
      counter_reg       <= counter_next;
      victory_reg       <= victory_next;
      victory_nonce_reg <= victory_nonce_next;
      exhausted_reg     <= exhausted_next;
`ifdef BCX_SWEEP_RESUME_EN
      win_count_reg     <= win_count_next;
`endif
    end
  end

  // Tag pipe mirrors the hash core latency; a flush kills every in-flight tag including the one entering now.
  generate
    for (genvar gi = 0; gi < PIPE_DEPTH; gi++) begin : g_tag
      if (gi == 0) begin : g_head
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            tag_valid_reg[0] <= 1'b0;
            tag_nonce_reg[0] <= 32'd0;
          end else begin
            tag_valid_reg[0] <= tag_flush ? 1'b0 : nonce_valid_o;
            tag_nonce_reg[0] <= nonce_o;
          end
        end
      end else begin : g_body
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            tag_valid_reg[gi] <= 1'b0;
            tag_nonce_reg[gi] <= 32'd0;
          end else begin
            tag_valid_reg[gi] <= tag_flush ? 1'b0 : tag_valid_reg[gi-1];
            tag_nonce_reg[gi] <= tag_nonce_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  logic                 pass_valid_reg   [PASS_STAGES];
  logic                 pass_newblk_reg  [PASS_STAGES];
  logic [PAYLOAD_W-1:0] pass_payload_reg [PASS_STAGES];

  generate
    for (genvar gi = 0; gi < PASS_STAGES; gi++) begin : g_pass
      if (gi == 0) begin : g_head
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            pass_valid_reg[0]   <= 1'b0;
            pass_newblk_reg[0]  <= 1'b0;
            pass_payload_reg[0] <= '0;
          end else begin
            pass_valid_reg[0]   <= in_valid;
            pass_newblk_reg[0]  <= in_newblock;
            pass_payload_reg[0] <= in_payload;
          end
        end
      end else begin : g_body
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            pass_valid_reg[gi]   <= 1'b0;
            pass_newblk_reg[gi]  <= 1'b0;
            pass_payload_reg[gi] <= '0;
          end else begin
            pass_valid_reg[gi]   <= pass_valid_reg[gi-1];
            pass_newblk_reg[gi]  <= pass_newblk_reg[gi-1];
            pass_payload_reg[gi] <= pass_payload_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  assign out_valid    = pass_valid_reg[PASS_STAGES-1];
  assign out_newblock = pass_newblk_reg[PASS_STAGES-1];
  assign out_payload  = pass_payload_reg[PASS_STAGES-1];

endmodule

// File: tb/tb_bcx_partitioned_nonce_processor.sv
// Scoreboard bench for bcx_partitioned_nonce_processor: 2-bit partition, slot 1, 6-bit nonces, 4-deep hash pipe.
// Resume-mode scenarios compile in when BCX_SWEEP_RESUME_EN is defined.
module tb_bcx_partitioned_nonce_processor;
  localparam int PW = 352;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_newblock = 1'b0;
  logic [PW-1:0] in_payload = '0;
  logic          out_valid;
  logic          out_newblock;
  logic [PW-1:0] out_payload;
  logic [31:0]   nonce_o;
  logic          nonce_valid_o;
  logic          hash_success_i = 1'b0;
  logic          victory;
  logic [31:0]   victory_nonce;
  logic          exhausted;
  logic          sweeping;
`ifdef BCX_SWEEP_RESUME_EN
  logic [7:0]    win_count;
`endif

  always #5 clk = ~clk;

  bcx_partitioned_nonce_processor #(
    .PARTITIONBITS(2), .PROCESSORNUMBER(1), .NONCE_BITS(6),
    .PIPE_DEPTH(4), .PAYLOAD_W(PW), .PASS_STAGES(3)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_newblock(in_newblock), .in_payload(in_payload),
    .out_valid(out_valid), .out_newblock(out_newblock), .out_payload(out_payload),
    .nonce_o(nonce_o), .nonce_valid_o(nonce_valid_o), .hash_success_i(hash_success_i),
    .victory(victory), .victory_nonce(victory_nonce), .exhausted(exhausted),
    .sweeping(sweeping)
`ifdef BCX_SWEEP_RESUME_EN
    , .win_count(win_count)
`endif
  );

  int checks_total  = 0;
  int checks_passed = 0;

  logic [31:0] exp_nonce_q[$];
  logic [31:0] exp_vic_q[$];
  logic [PW:0] exp_pay_q[$];
  int          exp_pay_cyc_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // The slot-1 sweep: {counter, 2'b01} for counter 0..15.
  task automatic push_sweep();
    for (int i = 0; i < 16; i++) exp_nonce_q.push_back(32'(4 * i + 1));
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks_total++;
    if ({nonce_valid_o, sweeping, exhausted, victory, out_valid, out_newblock} !== 6'b0)
      $display("FAIL reset_flags got=%b exp=000000",
               {nonce_valid_o, sweeping, exhausted, victory, out_valid, out_newblock});
    else checks_passed++;
    checks_total++;
    if (nonce_o !== 32'd0 || victory_nonce !== 32'd0)
      $display("FAIL reset_nonces got nonce=%h vnonce=%h exp 0/0", nonce_o, victory_nonce);
    else checks_passed++;
    checks_total++;
    if (out_payload !== '0) $display("FAIL reset_payload got nonzero exp 0");
    else checks_passed++;
`ifdef BCX_SWEEP_RESUME_EN
    checks_total++;
    if (win_count !== 8'd0) $display("FAIL reset_win_count got=%0d exp=0", win_count);
    else checks_passed++;
`endif
    rst = 1'b1;
    tick();
    $display("reset released");
  endtask

  task automatic test_exhaust();
    logic [31:0] exp_n;
    push_sweep();
    in_valid = 1'b1; in_newblock = 1'b1;
    tick();
    in_valid = 1'b0; in_newblock = 1'b0;
    for (int cyc = 1; cyc <= 22; cyc++) begin
      checks_total++;
      if (exp_nonce_q.size() > 0) begin
        exp_n = exp_nonce_q.pop_front();
        if (nonce_valid_o !== 1'b1 || nonce_o !== exp_n)
          $display("FAIL exhaust_nonce cyc=%0d got v=%b n=%h exp v=1 n=%h", cyc, nonce_valid_o, nonce_o, exp_n);
        else begin checks_passed++; $display("issue cyc=%0d nonce=%h", cyc, nonce_o); end
      end else if (nonce_valid_o !== 1'b0)
        $display("FAIL exhaust_idle cyc=%0d got v=%b exp v=0", cyc, nonce_valid_o);
      else checks_passed++;
      checks_total++;
      if ({victory, exhausted, sweeping} !== {1'b0, cyc >= 21, cyc <= 20})
        $display("FAIL exhaust_status cyc=%0d got vic/exh/swp=%b exp=%b", cyc,
                 {victory, exhausted, sweeping}, {1'b0, cyc >= 21, cyc <= 20});
      else checks_passed++;
      tick();
    end
    // in_newblock without in_valid must not restart a finished sweep.
    in_newblock = 1'b1;
    tick();
    in_newblock = 1'b0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      checks_total++;
      if ({nonce_valid_o, exhausted} !== 2'b01)
        $display("FAIL ignore_newblock cyc=%0d got v/exh=%b exp=01", cyc, {nonce_valid_o, exhausted});
      else checks_passed++;
      tick();
    end
  endtask

`ifndef BCX_SWEEP_RESUME_EN
  task automatic test_win();
    logic [31:0] exp_n;
    for (int i = 0; i < 7; i++) exp_nonce_q.push_back(32'(4 * i + 1));
    in_valid = 1'b1; in_newblock = 1'b1;
    tick();
    in_valid = 1'b0; in_newblock = 1'b0;
    for (int cyc = 1; cyc <= 24; cyc++) begin
      hash_success_i = (cyc == 7);
      if (cyc == 7) exp_vic_q.push_back(32'h09);
      checks_total++;
      if (exp_nonce_q.size() > 0) begin
        exp_n = exp_nonce_q.pop_front();
        if (nonce_valid_o !== 1'b1 || nonce_o !== exp_n)
          $display("FAIL win_nonce cyc=%0d got v=%b n=%h exp v=1 n=%h", cyc, nonce_valid_o, nonce_o, exp_n);
        else checks_passed++;
      end else if (nonce_valid_o !== 1'b0)
        $display("FAIL win_stop cyc=%0d got v=%b exp v=0", cyc, nonce_valid_o);
      else checks_passed++;
      checks_total++;
      if ({victory, exhausted, sweeping} !== {cyc >= 8, 1'b0, cyc <= 7})
        $display("FAIL win_status cyc=%0d got vic/exh/swp=%b exp=%b", cyc,
                 {victory, exhausted, sweeping}, {cyc >= 8, 1'b0, cyc <= 7});
      else checks_passed++;
      if (victory === 1'b1 && exp_vic_q.size() > 0) begin
        exp_n = exp_vic_q.pop_front();
        checks_total++;
        if (victory_nonce !== exp_n)
          $display("FAIL win_nonce_capture cyc=%0d got=%h exp=%h", cyc, victory_nonce, exp_n);
        else begin checks_passed++; $display("victory cyc=%0d nonce=%h", cyc, victory_nonce); end
      end
      tick();
    end
    hash_success_i = 1'b0;
    checks_total++;
    if (exp_vic_q.size() != 0 || victory_nonce !== 32'h09)
      $display("FAIL win_hold got pending=%0d vnonce=%h exp pending=0 vnonce=00000009",
               exp_vic_q.size(), victory_nonce);
    else checks_passed++;
    exp_vic_q.delete();
  endtask
`else
  task automatic test_resume_hits();
    logic [31:0] exp_n;
    push_sweep();
    in_valid = 1'b1; in_newblock = 1'b1;
    tick();
    in_valid = 1'b0; in_newblock = 1'b0;
    for (int cyc = 1; cyc <= 22; cyc++) begin
      hash_success_i = (cyc == 6) || (cyc == 13);
      if (cyc == 6)  exp_vic_q.push_back(32'h05);
      if (cyc == 13) exp_vic_q.push_back(32'h21);
      checks_total++;
      if (exp_nonce_q.size() > 0) begin
        exp_n = exp_nonce_q.pop_front();
        if (nonce_valid_o !== 1'b1 || nonce_o !== exp_n)
          $display("FAIL resume_nonce cyc=%0d got v=%b n=%h exp v=1 n=%h", cyc, nonce_valid_o, nonce_o, exp_n);
        else checks_passed++;
      end else if (nonce_valid_o !== 1'b0)
        $display("FAIL resume_idle cyc=%0d got v=%b exp v=0", cyc, nonce_valid_o);
      else checks_passed++;
      checks_total++;
      if ({victory, exhausted, sweeping} !== {(cyc == 7) || (cyc == 14), 1'b0, cyc <= 20})
        $display("FAIL resume_status cyc=%0d got vic/exh/swp=%b exp=%b", cyc,
                 {victory, exhausted, sweeping}, {(cyc == 7) || (cyc == 14), 1'b0, cyc <= 20});
      else checks_passed++;
      if (victory === 1'b1 && exp_vic_q.size() > 0) begin
        exp_n = exp_vic_q.pop_front();
        checks_total++;
        if (victory_nonce !== exp_n)
          $display("FAIL resume_capture cyc=%0d got=%h exp=%h", cyc, victory_nonce, exp_n);
        else begin checks_passed++; $display("victory cyc=%0d nonce=%h", cyc, victory_nonce); end
      end
      if (cyc == 8 || cyc == 22) begin
        checks_total++;
        if (win_count !== ((cyc == 8) ? 8'd1 : 8'd2))
          $display("FAIL resume_win_count cyc=%0d got=%0d exp=%0d", cyc, win_count, (cyc == 8) ? 1 : 2);
        else checks_passed++;
      end
      tick();
    end
    hash_success_i = 1'b0;
    checks_total++;
    if (exp_vic_q.size() != 0 || victory_nonce !== 32'h21)
      $display("FAIL resume_hold got pending=%0d vnonce=%h exp pending=0 vnonce=00000021",
               exp_vic_q.size(), victory_nonce);
    else checks_passed++;
    exp_vic_q.delete();
  endtask
`endif

  task automatic test_start_collision();
    logic [31:0] exp_n;
    for (int i = 0; i < 5; i++) exp_nonce_q.push_back(32'(4 * i + 1));
    in_valid = 1'b1; in_newblock = 1'b1;
    tick();
    for (int cyc = 1; cyc <= 27; cyc++) begin
      in_valid = (cyc == 5); in_newblock = (cyc == 5); hash_success_i = (cyc == 5);
      if (cyc == 5) push_sweep();
      checks_total++;
      if (exp_nonce_q.size() > 0) begin
        exp_n = exp_nonce_q.pop_front();
        if (nonce_valid_o !== 1'b1 || nonce_o !== exp_n)
          $display("FAIL collide_nonce cyc=%0d got v=%b n=%h exp v=1 n=%h", cyc, nonce_valid_o, nonce_o, exp_n);
        else checks_passed++;
      end else if (nonce_valid_o !== 1'b0)
        $display("FAIL collide_idle cyc=%0d got v=%b exp v=0", cyc, nonce_valid_o);
      else checks_passed++;
      checks_total++;
      if ({victory, exhausted, sweeping} !== {1'b0, cyc >= 26, cyc <= 25})
        $display("FAIL collide_status cyc=%0d got vic/exh/swp=%b exp=%b", cyc,
                 {victory, exhausted, sweeping}, {1'b0, cyc >= 26, cyc <= 25});
      else checks_passed++;
      tick();
    end
    in_valid = 1'b0; in_newblock = 1'b0; hash_success_i = 1'b0;
    $display("collision sweep finished");
  endtask

  task automatic test_restart_mid();
    logic [31:0] exp_n;
    for (int i = 0; i < 6; i++) exp_nonce_q.push_back(32'(4 * i + 1));
    in_valid = 1'b1; in_newblock = 1'b1;
    tick();
    for (int cyc = 1; cyc <= 28; cyc++) begin
      in_valid = (cyc == 6); in_newblock = (cyc == 6);
      hash_success_i = (cyc >= 7) && (cyc <= 10);
      if (cyc == 6) push_sweep();
      checks_total++;
      if (exp_nonce_q.size() > 0) begin
        exp_n = exp_nonce_q.pop_front();
        if (nonce_valid_o !== 1'b1 || nonce_o !== exp_n)
          $display("FAIL restart_nonce cyc=%0d got v=%b n=%h exp v=1 n=%h", cyc, nonce_valid_o, nonce_o, exp_n);
        else checks_passed++;
      end else if (nonce_valid_o !== 1'b0)
        $display("FAIL restart_idle cyc=%0d got v=%b exp v=0", cyc, nonce_valid_o);
      else checks_passed++;
      checks_total++;
      if ({victory, exhausted, sweeping} !== {1'b0, cyc >= 27, cyc <= 26})
        $display("FAIL restart_status cyc=%0d got vic/exh/swp=%b exp=%b", cyc,
                 {victory, exhausted, sweeping}, {1'b0, cyc >= 27, cyc <= 26});
      else checks_passed++;
      tick();
    end
    in_valid = 1'b0; in_newblock = 1'b0; hash_success_i = 1'b0;
`ifdef BCX_SWEEP_RESUME_EN
    checks_total++;
    if (win_count !== 8'd0) $display("FAIL restart_win_count got=%0d exp=0", win_count);
    else checks_passed++;
`endif
    $display("restart sweep finished");
  endtask

  task automatic test_passthrough();
    logic [PW-1:0] pay [4];
    logic [PW:0]   exp_p;
    int            exp_c;
    pay[0] = {44{8'hA5}};
    pay[1] = ~pay[0];
    for (int w = 0; w < 11; w++) pay[2][w*32 +: 32] = $urandom();
    pay[3] = {11{32'h0123_4567}};
    for (int cyc = 0; cyc <= 10; cyc++) begin
      if (out_valid === 1'b1) begin
        checks_total++;
        if (exp_pay_q.size() == 0)
          $display("FAIL pass_unexpected cyc=%0d got out_valid=1 exp none pending", cyc);
        else begin
          exp_p = exp_pay_q.pop_front();
          exp_c = exp_pay_cyc_q.pop_front();
          if ({out_newblock, out_payload} !== exp_p || cyc - exp_c != 3)
            $display("FAIL pass_data cyc=%0d got nb=%b pay[31:0]=%h lat=%0d exp nb=%b pay[31:0]=%h lat=3",
                     cyc, out_newblock, out_payload[31:0], cyc - exp_c, exp_p[PW], exp_p[31:0]);
          else begin
            checks_passed++;
            $display("pass cyc=%0d nb=%b pay[31:0]=%h", cyc, out_newblock, out_payload[31:0]);
          end
        end
      end else if (exp_pay_cyc_q.size() > 0 && cyc - exp_pay_cyc_q[0] >= 3) begin
        checks_total++;
        $display("FAIL pass_missing cyc=%0d got out_valid=0 exp valid item from cyc %0d", cyc, exp_pay_cyc_q[0]);
        void'(exp_pay_q.pop_front());
        void'(exp_pay_cyc_q.pop_front());
      end
      if (cyc < 4) begin
        in_valid = 1'b1; in_newblock = (cyc == 3); in_payload = pay[cyc];
        exp_pay_q.push_back({cyc == 3, pay[cyc]});
        exp_pay_cyc_q.push_back(cyc);
      end else begin
        in_valid = 1'b0; in_newblock = 1'b0; in_payload = '0;
      end
      tick();
    end
    checks_total++;
    if (exp_pay_q.size() != 0 || out_valid !== 1'b0)
      $display("FAIL pass_drain got pending=%0d out_valid=%b exp 0/0", exp_pay_q.size(), out_valid);
    else checks_passed++;
  endtask

  task automatic test_reset_drain();
    logic [31:0] exp_n;
    push_sweep();
    in_valid = 1'b1; in_newblock = 1'b1;
    tick();
    in_valid = 1'b0; in_newblock = 1'b0;
    for (int cyc = 1; cyc <= 18; cyc++) begin
      if (cyc >= 14) begin in_valid = 1'b1; in_payload = {44{8'hA5}}; end
      checks_total++;
      if (exp_nonce_q.size() > 0) begin
        exp_n = exp_nonce_q.pop_front();
        if (nonce_valid_o !== 1'b1 || nonce_o !== exp_n)
          $display("FAIL rstdrain_nonce cyc=%0d got v=%b n=%h exp v=1 n=%h", cyc, nonce_valid_o, nonce_o, exp_n);
        else checks_passed++;
      end else if ({nonce_valid_o, sweeping} !== 2'b01)
        $display("FAIL rstdrain_drain cyc=%0d got v/swp=%b exp=01", cyc, {nonce_valid_o, sweeping});
      else checks_passed++;
      if (cyc < 18) tick();
    end
    #2;
    rst = 1'b0;
    #1;
    checks_total++;
    if ({nonce_valid_o, sweeping, exhausted, victory, out_valid, out_newblock} !== 6'b0 ||
        nonce_o !== 32'd0 || victory_nonce !== 32'd0 || out_payload !== '0)
      $display("FAIL async_reset got flags=%b nonce=%h vnonce=%h payload_nonzero=%b exp all 0",
               {nonce_valid_o, sweeping, exhausted, victory, out_valid, out_newblock},
               nonce_o, victory_nonce, |out_payload);
    else begin checks_passed++; $display("async reset mid-drain cleared outputs"); end
    in_valid = 1'b0; in_payload = '0;
    tick();
    rst = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      tick();
      checks_total++;
      if ({nonce_valid_o, sweeping, exhausted} !== 3'b000)
        $display("FAIL post_reset_idle cyc=%0d got v/swp/exh=%b exp=000", cyc, {nonce_valid_o, sweeping, exhausted});
      else checks_passed++;
    end
    in_valid = 1'b1; in_newblock = 1'b1;
    tick();
    in_valid = 1'b0; in_newblock = 1'b0;
    checks_total++;
    if (nonce_valid_o !== 1'b1 || nonce_o !== 32'h01)
      $display("FAIL post_reset_start got v=%b n=%h exp v=1 n=00000001", nonce_valid_o, nonce_o);
    else checks_passed++;
  endtask

  initial begin
    test_reset();
    test_exhaust();
`ifdef BCX_SWEEP_RESUME_EN
    test_resume_hits();
`else
    test_win();
`endif
    test_start_collision();
    test_restart_mid();
    test_passthrough();
    test_reset_drain();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
